uart_tx_frame: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 sender. It accepts words from the upstream FIFO over a valid/ready handshake and serialises them LSB-first. Data width, stop-bit count and baud rate are set by parameters; parity is selected at run time. It sits between the sample FIFO read port and the board TX pin.

---
 rtl/uart_tx_frame.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word intake, LSB-first serialisation with
// configurable data width, stop-bit count and run-time selectable parity.
module uart_tx_frame #(
  parameter int CLK_FREQURENCE = 12000000,
  parameter int BAUD_RATE      = 115200,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int BIT_CNT        = CLK_FREQURENCE / BAUD_RATE
) (
  input  logic                 sysclk_12,
  input  logic                 i_rest,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx_data,
  output logic                 send_sta_flg,
  output logic                 tx_done
);

  localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int IDX_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_en;
  logic                 r_par_odd;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rst_q;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_tx_nxt;
  logic                 w_done_nxt;
  logic                 w_bit_end;
  logic                 w_accept;
  logic                 w_parity;

  // r_rst_q holds s_ready low for the cycles the reset is being applied
  assign s_ready      = (r_state == IDLE) && !r_rst_q;
  assign tx_data      = r_tx;
  assign send_sta_flg = r_busy;
  assign tx_done      = r_done;

  assign w_accept  = s_valid && s_ready;
  assign w_bit_end = (r_clk_cnt == CNT_LAST);
  assign w_parity  = (^r_data) ^ r_par_odd;

  always_ff @(posedge sysclk_12) begin
    if (i_rest) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rst_q   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_rst_q   <= 1'b0;
      if (w_accept) begin
        r_data    <= s_data;
        r_par_en  <= parity_en;
        r_par_odd <= parity_odd;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_idx_nxt   = r_bit_idx;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (w_accept) w_state_nxt = START;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == DATA_LAST) begin
            w_state_nxt = r_par_en ? PARITY : STOP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_idx_nxt   = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_bit_idx == STOP_LAST) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so tx_data leaves a register
  // aligned with the state it belongs to.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_data[w_idx_nxt];
      PARITY:  w_tx_nxt = w_parity;
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame: 8N1 default instance and a
// 5-data/2-stop instance with a short bit period.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       i_rest;
  logic [7:0] d0;
  logic       v0, r0, pe0, po0, tx0, busy0, done0;
  logic [4:0] d1;
  logic       v1, r1, pe1, po1, tx1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  logic obs_mid[16];
  int   obs_unstable[16];
  int   obs_done_cyc;
  int   obs_done_cnt;
  logic obs_busy1;
  logic obs_busy_at_done;
  logic obs_ready_at_done;

  always #5 clk = ~clk;

  uart_tx_frame dut0 (
    .sysclk_12(clk), .i_rest(i_rest), .s_data(d0), .s_valid(v0), .s_ready(r0),
    .parity_en(pe0), .parity_odd(po0), .tx_data(tx0), .send_sta_flg(busy0),
    .tx_done(done0)
  );

  uart_tx_frame #(
    .CLK_FREQURENCE(1000), .BAUD_RATE(100), .DATA_BITS(5), .STOP_BITS(2)
  ) dut1 (
    .sysclk_12(clk), .i_rest(i_rest), .s_data(d1), .s_valid(v1), .s_ready(r1),
    .parity_en(pe1), .parity_odd(po1), .tx_data(tx1), .send_sta_flg(busy1),
    .tx_done(done1)
  );

  // Presents one word and returns right after the accepting edge.
  task automatic accept(input int which, input logic [7:0] d, input logic pe,
                        input logic po, output logic ok);
    logic rdy;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (which == 0) begin v0 = 1'b1; d0 = d; pe0 = pe; po0 = po; rdy = r0; end
      else begin v1 = 1'b1; d1 = d[4:0]; pe1 = pe; po1 = po; rdy = r1; end
      @(posedge clk);
      if (rdy === 1'b1) ok = 1'b1;
    end
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Records the line per bit and the end-of-frame behaviour; no judgement here.
  task automatic capture(input int which, input int nbits, input int bc);
    logic t, dn, b, r, first;
    int   bi, off;
    obs_done_cyc = -1;
    obs_done_cnt = 0;
    obs_busy1 = 1'bx;
    obs_busy_at_done = 1'bx;
    obs_ready_at_done = 1'bx;
    for (int i = 0; i < 16; i++) begin obs_mid[i] = 1'bx; obs_unstable[i] = 0; end
    first = 1'b1;
    for (int k = 1; k <= nbits * bc + 3; k++) begin
      @(negedge clk);
      if (which == 0) begin t = tx0; dn = done0; b = busy0; r = r0; end
      else begin t = tx1; dn = done1; b = busy1; r = r1; end
      if (k == 1) obs_busy1 = b;
      if (k <= nbits * bc) begin
        bi = (k - 1) / bc;
        off = (k - 1) % bc;
        if (off == 0) first = t;
        else if (t !== first) obs_unstable[bi]++;
        if (off == bc / 2) obs_mid[bi] = t;
      end
      if (dn === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = k;
          obs_busy_at_done = b;
          obs_ready_at_done = r;
        end
      end
    end
  endtask

  task automatic test_reset;
    int lows;
    i_rest = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    pe0 = 1'b0; po0 = 1'b0; pe1 = 1'b0; po1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b expected 0/0", r0, r1);
    end
    n_checks++;
    if (tx0 !== 1'b1 || tx1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx: got %b/%b expected 1/1", tx0, tx1);
    end
    n_checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy %b/%b done %b/%b expected all 0",
                         busy0, busy1, done0, done1);
    end
    i_rest = 1'b0;
    @(negedge clk);
    n_checks++;
    if (r0 !== 1'b1 || r1 !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b/%b expected 1/1", r0, r1);
    end
    lows = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 0) begin
      n_fail++; $display("FAIL idle_line: got %0d non-idle cycles expected 0", lows);
    end
  endtask

  task automatic test_8n1;
    logic ok;
    logic [15:0] e;
    e = '1;
    e[9:0] = {1'b1, 8'hA5, 1'b0};
    accept(0, 8'hA5, 1'b0, 1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL a5_accept: got %b expected 1", ok); end
    capture(0, 10, 104);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (obs_mid[b] !== e[b] || obs_unstable[b] !== 0) begin
        n_fail++; $display("FAIL a5_bit%0d: got %b (unstable %0d) expected %b",
                           b, obs_mid[b], obs_unstable[b], e[b]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 1041) begin
      n_fail++; $display("FAIL a5_done_cycle: got %0d expected 1041", obs_done_cyc);
    end
    n_checks++;
    if (obs_done_cnt !== 1) begin
      n_fail++; $display("FAIL a5_done_count: got %0d expected 1", obs_done_cnt);
    end
    n_checks++;
    if (obs_busy1 !== 1'b1) begin
      n_fail++; $display("FAIL a5_busy_first: got %b expected 1", obs_busy1);
    end
    n_checks++;
    if (obs_busy_at_done !== 1'b0 || obs_ready_at_done !== 1'b1) begin
      n_fail++; $display("FAIL a5_end_state: busy %b ready %b expected 0 1",
                         obs_busy_at_done, obs_ready_at_done);
    end
  endtask

  task automatic test_parity;
    logic ok;
    logic [15:0] e;
    for (int m = 0; m < 3; m++) begin
      // m=0 even, m=1 odd, m=2 even with inputs scrambled mid-frame
      e = '1;
      e[10:0] = {1'b1, (m == 1) ? 1'b0 : 1'b1, 8'h07, 1'b0};
      accept(0, 8'h07, 1'b1, (m == 1) ? 1'b1 : 1'b0, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL par%0d_accept: got %b expected 1", m, ok); end
      if (m == 2) begin
        fork
          capture(0, 11, 104);
          begin
            repeat (200) @(negedge clk);
            po0 = 1'b1; pe0 = 1'b0; d0 = 8'hFF;
          end
        join
      end else begin
        capture(0, 11, 104);
      end
      for (int b = 0; b < 11; b++) begin
        n_checks++;
        if (obs_mid[b] !== e[b] || obs_unstable[b] !== 0) begin
          n_fail++; $display("FAIL par%0d_bit%0d: got %b (unstable %0d) expected %b",
                             m, b, obs_mid[b], obs_unstable[b], e[b]);
        end
      end
      n_checks++;
      if (obs_done_cyc !== 11 * 104 + 1 || obs_done_cnt !== 1) begin
        n_fail++; $display("FAIL par%0d_done: got cycle %0d count %0d expected 1145 1",
                           m, obs_done_cyc, obs_done_cnt);
      end
    end
    po0 = 1'b0; pe0 = 1'b0;
  endtask

  task automatic test_5n2;
    logic ok;
    logic [15:0] e;
    e = '1;
    e[7:0] = {2'b11, 5'h13, 1'b0};
    accept(1, 8'h13, 1'b0, 1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL n52_accept: got %b expected 1", ok); end
    capture(1, 8, 10);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (obs_mid[b] !== e[b] || obs_unstable[b] !== 0) begin
        n_fail++; $display("FAIL n52_bit%0d: got %b (unstable %0d) expected %b",
                           b, obs_mid[b], obs_unstable[b], e[b]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 81 || obs_done_cnt !== 1) begin
      n_fail++; $display("FAIL n52_done: got cycle %0d count %0d expected 81 1",
                         obs_done_cyc, obs_done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    int sent, acc, dones, starts;
    int start_cyc [3];
    logic prev_busy, rdy;
    words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h5A;
    sent = 0; acc = 0; dones = 0; starts = 0; prev_busy = 1'b0;
    for (int i = 0; i < 3; i++) start_cyc[i] = 0;
    for (int k = 0; k < 3 * 1041 + 200; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) dones++;
      if (busy0 === 1'b1 && prev_busy === 1'b0) begin
        if (starts < 3) start_cyc[starts] = k;
        starts++;
      end
      prev_busy = busy0;
      v0 = (sent < 3);
      if (sent < 3) d0 = words[sent];
      pe0 = 1'b0;
      rdy = r0;
      @(posedge clk);
      if (v0 && rdy === 1'b1) begin acc++; sent++; end
    end
    #1 v0 = 1'b0;
    n_checks++;
    if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
    n_checks++;
    if (dones !== 3) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d expected 3", dones); end
    n_checks++;
    if (starts !== 3) begin n_fail++; $display("FAIL b2b_starts: got %0d expected 3", starts); end
    n_checks++;
    if (start_cyc[1] - start_cyc[0] !== 1041) begin
      n_fail++; $display("FAIL b2b_gap01: got %0d expected 1041", start_cyc[1] - start_cyc[0]);
    end
    n_checks++;
    if (start_cyc[2] - start_cyc[1] !== 1041) begin
      n_fail++; $display("FAIL b2b_gap12: got %0d expected 1041", start_cyc[2] - start_cyc[1]);
    end
  endtask

  task automatic test_reset_midframe;
    logic ok;
    logic [15:0] e;
    int bad;
    accept(0, 8'hA5, 1'b0, 1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rm_accept: got %b expected 1", ok); end
    repeat (104 * 5 + 52) @(negedge clk);
    n_checks++;
    if (tx0 !== 1'b0) begin n_fail++; $display("FAIL rm_bit4_line: got %b expected 0", tx0); end
    i_rest = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL rm_abort: tx %b busy %b done %b expected 1 0 0", tx0, busy0, done0);
    end
    @(negedge clk);
    i_rest = 1'b0;
    bad = 0;
    repeat (1200) begin
      @(negedge clk);
      if (done0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rm_quiet: got %0d active cycles expected 0", bad); end
    e = '1;
    e[9:0] = {1'b1, 8'h5A, 1'b0};
    accept(0, 8'h5A, 1'b0, 1'b0, ok);
    capture(0, 10, 104);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (obs_mid[b] !== e[b] || obs_unstable[b] !== 0) begin
        n_fail++; $display("FAIL rm_next_bit%0d: got %b (unstable %0d) expected %b",
                           b, obs_mid[b], obs_unstable[b], e[b]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 1041 || obs_done_cnt !== 1) begin
      n_fail++; $display("FAIL rm_next_done: got cycle %0d count %0d expected 1041 1",
                         obs_done_cyc, obs_done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_5n2();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
